// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Register-file front end that sequences commands into a
//            combinational ALU (accept -> settle -> writeback).
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
   parameter int W  = 4,
   parameter int SW = 3,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [SW-1:0] cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_src_a,
   input  logic [AW-1:0] cmd_src_b,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [W-1:0]  ld_data,
   output logic [SW-1:0] alu_s,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   input  logic [W-1:0]  alu_f,
   output logic [W-1:0]  result,
   output logic          done,
   input  logic [AW-1:0] dbg_addr,
   output logic [W-1:0]  dbg_data
);

   localparam int DEPTH = 2**AW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t          state_q;
   logic [W-1:0]    rf_q [DEPTH];
   logic [SW-1:0]   alu_s_q;
   logic [W-1:0]    alu_a_q;
   logic [W-1:0]    alu_b_q;
   logic [AW-1:0]   dst_q;
   logic [W-1:0]    result_q;
   logic            done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         alu_s_q  <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         dst_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         // Load is issued first so a same-address writeback below overrides it.
         if (ld_valid) begin
            rf_q[ld_addr] <= ld_data;
         end
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  alu_s_q <= cmd_op;
                  alu_a_q <= rf_q[cmd_src_a];
                  alu_b_q <= rf_q[cmd_src_b];
                  dst_q   <= cmd_dst;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               state_q <= WB;
            end
            WB: begin
               rf_q[dst_q] <= alu_f;
               result_q    <= alu_f;
               done_q      <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign alu_s     = alu_s_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign result    = result_q;
   assign done      = done_q;
   assign dbg_data  = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Directed self-checking bench for alu_issue_ctrl with an ALU stub.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_dst;
   logic [1:0] cmd_src_a;
   logic [1:0] cmd_src_b;
   logic       ld_valid;
   logic [1:0] ld_addr;
   logic [3:0] ld_data;
   logic [2:0] alu_s;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_f;
   logic [3:0] result;
   logic       done;
   logic [1:0] dbg_addr;
   logic [3:0] dbg_data;

   int n_vec;
   int n_err;

   alu_issue_ctrl #(.W(4), .SW(3), .AW(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_dst   (cmd_dst),
      .cmd_src_a (cmd_src_a),
      .cmd_src_b (cmd_src_b),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .alu_s     (alu_s),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .result    (result),
      .done      (done),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   // ALU stub: add, xor, otherwise pass A
   always_comb begin
      case (alu_s)
         3'b000:  alu_f = alu_a + alu_b;
         3'b001:  alu_f = alu_a ^ alu_b;
         default: alu_f = alu_a;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_rf(input string tag, input logic [1:0] addr, input logic [3:0] exp);
      dbg_addr = addr;
      #1;
      chk(tag, {28'd0, dbg_data}, {28'd0, exp});
   endtask

   task automatic load(input logic [1:0] addr, input logic [3:0] data);
      ld_valid = 1'b1;
      ld_addr  = addr;
      ld_data  = data;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic present(input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] a, input logic [1:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dst   = dst;
      cmd_src_a = a;
      cmd_src_b = b;
   endtask

   initial begin
      int seen;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      dbg_addr = '0;

      // Reset
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_done",  {31'd0, done},      32'd0);
      chk("rst_alu_s", {29'd0, alu_s},     32'd0);
      chk("rst_alu_a", {28'd0, alu_a},     32'd0);
      chk("rst_alu_b", {28'd0, alu_b},     32'd0);
      chk("rst_result",{28'd0, result},    32'd0);
      for (int i = 0; i < 4; i++) chk_rf("rst_rf", 2'(i), 4'h0);

      // Loads, then add r0+r1 -> r2
      load(2'd0, 4'b0101);
      load(2'd1, 4'b1001);
      chk_rf("ld_r0", 2'd0, 4'b0101);
      chk_rf("ld_r1", 2'd1, 4'b1001);
      present(3'b000, 2'd2, 2'd0, 2'd1);
      tick();                                  // accept edge k
      present(3'b001, 2'd3, 2'd2, 2'd0);       // held back-to-back command
      chk("add_s", {29'd0, alu_s}, 32'd0);
      chk("add_a", {28'd0, alu_a}, 32'h5);
      chk("add_b", {28'd0, alu_b}, 32'h9);
      chk("add_rdy_k1", {31'd0, cmd_ready}, 32'd0);
      chk("add_done_k1", {31'd0, done}, 32'd0);
      tick();                                  // k+1
      chk("add_rdy_k2", {31'd0, cmd_ready}, 32'd0);
      chk("add_done_k2", {31'd0, done}, 32'd0);
      tick();                                  // k+2 writeback
      chk("add_done", {31'd0, done}, 32'd1);
      chk("add_result", {28'd0, result}, 32'hE);
      chk("add_rdy_wb", {31'd0, cmd_ready}, 32'd1);
      chk_rf("add_rf2", 2'd2, 4'b1110);

      // Second command accepted at k+3, sees updated r2
      tick();
      cmd_valid = 1'b0;
      chk("xor_done_clr", {31'd0, done}, 32'd0);
      chk("xor_s", {29'd0, alu_s}, 32'd1);
      chk("xor_a", {28'd0, alu_a}, 32'hE);
      chk("xor_b", {28'd0, alu_b}, 32'h5);
      chk("xor_rdy1", {31'd0, cmd_ready}, 32'd0);
      tick();
      chk("xor_rdy2", {31'd0, cmd_ready}, 32'd0);
      tick();
      chk("xor_done", {31'd0, done}, 32'd1);
      chk("xor_result", {28'd0, result}, 32'hB);
      chk_rf("xor_rf3", 2'd3, 4'b1011);
      tick();
      chk("idle_no_done", {31'd0, done}, 32'd0);
      chk("idle_hold_s", {29'd0, alu_s}, 32'd1);

      // Load on accept edge: operand sees pre-load value
      load(2'd1, 4'b0111);
      present(3'b010, 2'd2, 2'd1, 2'd0);
      ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 4'hF;
      tick();
      cmd_valid = 1'b0;
      ld_valid = 1'b0;
      chk("pre_ld_a", {28'd0, alu_a}, 32'h7);
      chk_rf("pre_ld_r1", 2'd1, 4'hF);
      tick();
      // Same-address collision on writeback edge: writeback wins
      ld_valid = 1'b1; ld_addr = 2'd2; ld_data = 4'h0;
      tick();
      ld_valid = 1'b0;
      chk("col_done", {31'd0, done}, 32'd1);
      chk("col_result", {28'd0, result}, 32'h7);
      chk_rf("col_rf2", 2'd2, 4'b0111);

      // Different-address load on writeback edge: both land
      present(3'b000, 2'd0, 2'd1, 2'd1);
      tick();
      cmd_valid = 1'b0;
      tick();
      ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 4'hA;
      tick();
      ld_valid = 1'b0;
      chk("dif_result", {28'd0, result}, 32'hE);
      chk_rf("dif_rf0", 2'd0, 4'hE);
      chk_rf("dif_rf3", 2'd3, 4'hA);

      // Reset while in EXEC aborts the operation
      present(3'b000, 2'd1, 2'd0, 2'd0);
      tick();
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_alu_a", {28'd0, alu_a}, 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) seen++;
         tick();
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      chk("abort_result", {28'd0, result}, 32'd0);
      chk("abort_alu_s", {29'd0, alu_s}, 32'd0);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 4; i++) chk_rf("abort_rf", 2'(i), 4'h0);

      // Normal operation after abort
      load(2'd0, 4'h3);
      load(2'd1, 4'h4);
      present(3'b000, 2'd2, 2'd0, 2'd1);
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         tick();
         cmd_valid = 1'b0;
         if (done) seen = 1;
      end
      chk("post_done_seen", 32'(seen), 32'd1);
      chk("post_result", {28'd0, result}, 32'h7);
      chk_rf("post_rf2", 2'd2, 4'h7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
